// File: rtl/data_memory_responder.sv
// Byte-addressed, little-endian data memory for the RV32I core.
// Accepts one load/store per req, answers with a one-cycle ready after WAIT_CYCLES wait states.
module data_memory_responder #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size_control,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err
);

    localparam int         WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0]       mem [WORDS];
    state_t            state;
    logic [3:0]        cnt;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [2:0]        l_size;
    logic [31:0]       l_wdata;
    resp_t             next_resp;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lanes;

    // Legality check plus load extraction for one access against the word it targets.
    function automatic resp_t evaluate(input logic w, input logic [1:0] lane,
                                       input logic [2:0] sz, input logic [31:0] word);
        resp_t       r;
        logic [31:0] sh;
        logic        bad;
        r  = '0;
        sh = word >> {lane, 3'b000};
        case (sz)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lane[0];
            3'b010:         bad = (lane != 2'b00);
            default:        bad = 1'b1;
        endcase
        if (w && sz[2]) bad = 1'b1;
        r.err = bad;
        if (!bad && !w) begin
            case (sz)
                3'b000:  r.data = {{24{sh[7]}}, sh[7:0]};
                3'b100:  r.data = {24'b0, sh[7:0]};
                3'b001:  r.data = {{16{sh[15]}}, sh[15:0]};
                3'b101:  r.data = {16'b0, sh[15:0]};
                default: r.data = word;
            endcase
        end
        return r;
    endfunction

    // With zero wait states the response is formed on the accepting edge, so use the live inputs.
    always_comb begin
        if (state == IDLE)
            next_resp = evaluate(we, addr[1:0], size_control, mem[addr[ADDR_W-1:2]]);
        else
            next_resp = evaluate(l_we, l_addr[1:0], l_size, mem[l_addr[ADDR_W-1:2]]);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        byte_en     = 4'hF;
        wdata_lanes = l_wdata << {l_addr[1:0], 3'b000};
        case (l_size[1:0])
            2'b00:   byte_en = 4'b0001 << l_addr[1:0];
            2'b01:   byte_en = 4'b0011 << {l_addr[1], 1'b0};
            default: byte_en = 4'hF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_size  <= '0;
            l_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        l_we    <= we;
                        l_addr  <= addr;
                        l_size  <= size_control;
                        l_wdata <= wdata;
                        cnt     <= CNT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= next_resp.err;
                            rdata <= next_resp.data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= next_resp.err;
                        rdata <= next_resp.data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents survive rst and a reset in RESP leaves state IDLE, so no write.
    always_ff @(posedge clk) begin
        if (state == RESP && l_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[l_addr[ADDR_W-1:2]][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected responses are queued at issue
// and popped by a monitor whenever ready is seen.
module tb_data_memory_responder;

    typedef struct {
        logic        err;
        logic [31:0] data;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [6:0]  addr;
    logic [2:0]  size_control;
    logic [31:0] wdata, rdata;
    logic        ready, err;

    logic        req0, we0;
    logic [6:0]  addr0;
    logic [2:0]  size0;
    logic [31:0] wdata0, rdata0;
    logic        ready0, err0;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_words [32];

    data_memory_responder #(.ADDR_W(7), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .size_control(size_control), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err)
    );

    data_memory_responder #(.ADDR_W(7), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0),
        .size_control(size0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_err"}, {31'b0, err}, {31'b0, e.err});
                check({e.tag, "_rdata"}, rdata, e.data);
            end
        end
    end

    // Issue one request, scramble the inputs after acceptance, and time the response.
    task automatic do_req(input logic w, input logic [6:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic e_err, input logic [31:0] e_data,
                          input string tag);
        int lat;
        sb_q.push_back('{e_err, e_data, tag});
        @(negedge clk);
        req = 1'b1; we = w; addr = a; size_control = sz; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; addr = 7'($urandom); size_control = 3'($urandom); wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ready !== 1'b1 && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, lane;
        logic [31:0] d;
        logic [15:0] h;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size_control = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = '0; wdata0 = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b1;

        do_req(1'b1, 7'h04, 3'b010, 32'h0123_4567, 1'b0, 32'h0, "st_w04");
        do_req(1'b1, 7'h10, 3'b010, 32'hCAFE_F00D, 1'b0, 32'h0, "st_w10");

        do_req(1'b1, 7'h08, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0, "st_w08");
        do_req(1'b0, 7'h08, 3'b010, 32'h0, 1'b0, 32'hDEAD_BEEF, "ld_w08");

        do_req(1'b0, 7'h0B, 3'b000, 32'h0, 1'b0, 32'hFFFF_FFDE, "ld_b0b");
        do_req(1'b0, 7'h0B, 3'b100, 32'h0, 1'b0, 32'h0000_00DE, "ld_bu0b");
        do_req(1'b0, 7'h08, 3'b101, 32'h0, 1'b0, 32'h0000_BEEF, "ld_hu08");
        do_req(1'b0, 7'h0A, 3'b001, 32'h0, 1'b0, 32'hFFFF_DEAD, "ld_h0a");

        do_req(1'b1, 7'h09, 3'b000, 32'h0000_0012, 1'b0, 32'h0, "st_b09");
        do_req(1'b0, 7'h08, 3'b010, 32'h0, 1'b0, 32'hDEAD_12EF, "ld_w08_after_b");

        do_req(1'b0, 7'h06, 3'b010, 32'h0, 1'b1, 32'h0, "ld_w06_misalign");
        do_req(1'b1, 7'h05, 3'b001, 32'h0000_AAAA, 1'b1, 32'h0, "st_h05_misalign");
        do_req(1'b0, 7'h04, 3'b011, 32'h0, 1'b1, 32'h0, "ld_size011");
        do_req(1'b1, 7'h04, 3'b100, 32'hFFFF_FFFF, 1'b1, 32'h0, "st_size100");
        do_req(1'b0, 7'h04, 3'b010, 32'h0, 1'b0, 32'h0123_4567, "ld_w04_unchanged");

        for (int i = 0; i < 6; i++) begin
            idx  = 16 + int'($urandom_range(0, 15));
            d    = $urandom;
            lane = 2 * int'($urandom_range(0, 1));
            tb_words[idx] = d;
            do_req(1'b1, 7'(idx * 4), 3'b010, d, 1'b0, 32'h0, "rnd_st_w");
            h = 16'(d >> (lane * 8));
            do_req(1'b0, 7'(idx * 4 + lane), 3'b001, 32'h0, 1'b0, {{16{h[15]}}, h}, "rnd_ld_h");
            do_req(1'b0, 7'(idx * 4 + 3), 3'b100, 32'h0, 1'b0, {24'b0, tb_words[idx][31:24]}, "rnd_ld_bu");
        end

        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h00; size0 = 3'b010; wdata0 = 32'h5555_AAAA;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_ready", {31'b0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check("b2b_err", {31'b0, err0}, 32'd0);
        end
        req0 = 1'b0;

        do_req(1'b0, 7'h10, 3'b010, 32'h0, 1'b0, 32'hCAFE_F00D, "ld_w10_pre");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 7'h10; size_control = 3'b010; wdata = 32'h1111_1111;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rst_ready", {31'b0, ready}, 32'd0);
        check("abort_rst_err", {31'b0, err}, 32'd0);
        check("abort_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ready", {31'b0, ready}, 32'd0);
        end
        do_req(1'b0, 7'h10, 3'b010, 32'h0, 1'b0, 32'hCAFE_F00D, "ld_w10_after_abort");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory responder for the RV32I core; the core issues load/store requests, and this block stores and serves the data.
- Byte-addressed and little-endian.
- Uses a req/ready handshake with a configurable number of wait states.
- Supports byte/half/word stores and signed/unsigned loads with funct3 size encoding. Flags misaligned and illegal-size accesses.

Parameters:
ADDR_W, 7, byte-address width (matches the core's 7-bit data address).
WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (0 = reset)
req  input  1  request strobe from core
we  input  1  1 = store, 0 = load; sampled with req
addr  input  ADDR_W  byte address; sampled with req
size_control  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
wdata  input  32  store data, right-aligned; sampled with req
rdata  output  32  load result, sign/zero-extended
ready  output  1  one-cycle response strobe
err  output  1  error flag, valid only while ready=1

Behaviour:
- Storage: 2**ADDR_W bytes, organized as 2**(ADDR_W-2) 32-bit words. The word index is addr[ADDR_W-1:2] and the byte lane is addr[1:0]. Contents are not cleared by reset.
- Reset (rst=0, async): state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a rising edge with req=1, latch we/addr/size_control/wdata. Go to WAIT if WAIT_CYCLES>0, else go to RESP. The counter loads WAIT_CYCLES-1.
  - WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
  - RESP: ready=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: ready is high in the (WAIT_CYCLES+1)-th cycle after the accepting edge.
- Back-to-back requests: a new request can be accepted on the edge that leaves RESP only if the FSM is in IDLE. Therefore the minimum request period is WAIT_CYCLES+2 cycles.
- req is ignored in WAIT and RESP. Latched operands are not affected by input changes after acceptance.
- Alignment and legality, checked on the latched values:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=0.
  - size_control of 011, 110 or 111 is illegal for loads.
  - For stores, any size other than 000/001/010 is illegal.
- Error response: err=1 with ready, rdata=0, and no memory write.
- Store commit: the write happens on the edge leaving RESP, and only when err=0.
  - B writes the lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0] (low byte at the lower address).
  - W writes all four lanes.
  - Other lanes are untouched.
- Load data: computed from memory and driven on rdata in RESP.
  - B sign-extends and BU zero-extends the selected byte.
  - H/HU extend the selected halfword in the same way.
  - W returns the word unchanged.
- Output hold: rdata and err hold their RESP values until the next RESP or reset. A store response drives rdata=0.
- Reset mid-transaction (in WAIT or RESP): the pending transaction is abandoned, no write occurs, and no ready is produced. Memory is otherwise unchanged.
- The response reads the memory state as of its RESP cycle. A load following a store to the same word sees the stored data.

Test Plan:
1. WAIT_CYCLES=1: store W addr=0x08 wdata=0xDEADBEEF, then load W addr=0x08 -> the store response has ready high 2 cycles after acceptance with err=0; the load returns rdata=0xDEADBEEF.
2. After scenario 1, load B addr=0x0B and BU addr=0x0B -> rdata=0xFFFFFFDE, then 0x000000DE; load HU addr=0x08 -> 0x0000BEEF; load H addr=0x0A -> 0xFFFFDEAD.
3. Store B addr=0x09 wdata=0x00000012, then load W addr=0x08 -> 0xDEAD12EF (only lane 1 is changed).
4. Load W addr=0x06; store H addr=0x05; load with size_control=011 -> each response has err=1 and rdata=0; a following load W addr=0x04 shows the word is unchanged.
5. req held high continuously with WAIT_CYCLES=0 -> ready pulses every 2 cycles, and each pulse is exactly 1 cycle wide.
6. Store W addr=0x10 wdata=0x11111111 is accepted, rst pulsed low during WAIT, then load W addr=0x10 -> no ready for the aborted store; ready/err/rdata are 0 during reset; the load returns the prior contents.
